// File: rtl/effect_dac_pkg.sv
// Shared constants and types for the effect-chain DAC transmitter.
//   PCM_WIDTH        : PCM word width (24)
//   PCM_MAX/PCM_MIN  : saturation limits for signed 24-bit PCM
//   FLOAT_EXP_BIAS   : IEEE-754 single exponent bias
//   FLOAT_EXP_MIN_NZ : smallest exponent that can yield a non-zero PCM word
//   pcm_t            : signed PCM sample type
//   float_class_t    : converter classification of an input float
package effect_dac_pkg;

    localparam int unsigned PCM_WIDTH        = 24;
    localparam logic [23:0] PCM_MAX          = 24'h7FFFFF;
    localparam logic [23:0] PCM_MIN          = 24'h800000;
    localparam int unsigned FLOAT_EXP_BIAS   = 127;
    localparam int unsigned FLOAT_EXP_MIN_NZ = 104;

    typedef logic signed [PCM_WIDTH-1:0] pcm_t;

    typedef enum logic [1:0] {
        FcZero,
        FcShift,
        FcSatPos,
        FcSatNeg
    } float_class_t;

endpackage

// File: rtl/float_to_pcm.sv
// Two-stage pipelined IEEE-754 single to signed 24-bit PCM converter.
// Stage 1 classifies the float and computes the right-shift amount; stage 2
// shifts, applies the sign and registers the result.
// Ports:
//   clk, aclr  : clock, asynchronous active-high reset
//   in_valid   : sample strobe
//   sample     : IEEE-754 single input
//   out_valid  : result strobe, two cycles after in_valid
//   pcm        : saturated, truncated-toward-zero PCM result
module float_to_pcm
    import effect_dac_pkg::*;
(
    input  logic        clk,
    input  logic        aclr,
    input  logic        in_valid,
    input  logic [31:0] sample,
    output logic        out_valid,
    output pcm_t        pcm
);

    logic [7:0]   exp_f;
    logic [22:0]  frac_f;
    float_class_t cls_d;
    logic [4:0]   shift_d;

    logic         s1_valid_q;
    logic         s1_sign_q;
    float_class_t s1_cls_q;
    logic [23:0]  s1_mant_q;
    logic [4:0]   s1_shift_q;

    logic [23:0]  mag;
    pcm_t         pcm_d;
    logic         s2_valid_q;
    pcm_t         s2_pcm_q;

    assign exp_f  = sample[30:23];
    assign frac_f = sample[22:0];

    always_comb begin
        cls_d   = FcZero;
        shift_d = '0;
        if (exp_f == 8'd0) begin
            cls_d = FcZero;
        end else if (exp_f == 8'hFF && frac_f != '0) begin
            cls_d = FcZero;
        end else if (exp_f >= 8'(FLOAT_EXP_BIAS)) begin
            // Covers |x| >= 1.0 and Inf: full-scale saturation.
            cls_d = sample[31] ? FcSatNeg : FcSatPos;
        end else if (exp_f >= 8'(FLOAT_EXP_MIN_NZ)) begin
            cls_d   = FcShift;
            shift_d = 5'(8'(FLOAT_EXP_BIAS) - exp_f);
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_cls_q   <= FcZero;
            s1_mant_q  <= '0;
            s1_shift_q <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= sample[31];
            s1_cls_q   <= cls_d;
            s1_mant_q  <= {1'b1, frac_f};
            s1_shift_q <= shift_d;
        end
    end

    // Shift is at least 1, so the magnitude always fits in 23 bits.
    assign mag = s1_mant_q >> s1_shift_q;

    always_comb begin
        pcm_d = '0;
        case (s1_cls_q)
            FcShift:  pcm_d = s1_sign_q ? pcm_t'(~mag + 24'd1) : pcm_t'(mag);
            FcSatPos: pcm_d = pcm_t'(PCM_MAX);
            FcSatNeg: pcm_d = pcm_t'(PCM_MIN);
            default:  pcm_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s2_valid_q <= 1'b0;
            s2_pcm_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_pcm_q   <= pcm_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign pcm       = s2_pcm_q;

endmodule

// File: rtl/effect_dac_tx.sv
// Effect-chain output stage: float samples -> 24-bit PCM -> FIFO -> I2S.
// Mono source; each held sample is sent on both left and right slots.
// Optional feature macro: DAC_TX_MUTE_EN adds the `mute` input, which loads
// zero into the held sample at the next frame boundary.
// Ports:
//   clk, aclr     : clock, asynchronous active-high reset
//   sample_in     : IEEE-754 single sample
//   sample_valid  : one-cycle sample strobe
//   clear_flags   : synchronous clear of overflow/underflow
//   mute          : (DAC_TX_MUTE_EN only) zero the next frames
//   bclk, lrclk   : I2S bit clock and word select (0 = left)
//   sdata         : I2S serial data, MSB first
//   overflow      : sticky, a converted word was dropped on a full FIFO
//   underflow     : sticky, a frame started with the FIFO empty
module effect_dac_tx
    import effect_dac_pkg::*;
#(
    parameter int unsigned PCM_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    input  logic        clear_flags,
`ifdef DAC_TX_MUTE_EN
    input  logic        mute,
`endif
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DivW = $clog2(BCLK_DIV);

    logic conv_valid;
    pcm_t conv_pcm;

    float_to_pcm u_conv (
        .clk       (clk),
        .aclr      (aclr),
        .in_valid  (sample_valid),
        .sample    (sample_in),
        .out_valid (conv_valid),
        .pcm       (conv_pcm)
    );

    logic mute_active;
`ifdef DAC_TX_MUTE_EN
    assign mute_active = mute;
`else
    assign mute_active = 1'b0;
`endif

    // Bit-clock divider; serializer acts only on the bclk 1->0 cycle.
    logic [DivW-1:0] div_q, div_d;
    logic            bclk_q, bclk_d;
    logic            tick, fall;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [5:0]      n;
    logic            frame_start;

    always_comb begin
        tick   = (div_q == DivW'(BCLK_DIV - 1));
        div_d  = tick ? '0 : div_q + DivW'(1);
        bclk_d = tick ? ~bclk_q : bclk_q;
        fall   = tick & bclk_q;
        n      = bit_cnt_q + 6'd1;
        bit_cnt_d   = fall ? n : bit_cnt_q;
        frame_start = fall && (n == 6'd0);
    end

    // FIFO
    logic [PCM_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic                 ovf_set, unf_set;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CntW'(FIFO_DEPTH));
        pop        = frame_start & ~fifo_empty;
        // Pop is resolved before the write, so a full FIFO still accepts.
        push       = conv_valid & (~fifo_full | pop);
        ovf_set    = conv_valid & fifo_full & ~pop;
        unf_set    = frame_start & fifo_empty;
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv_pcm;
        end
    end

    // Serializer
    logic [PCM_WIDTH-1:0] held_q, held_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [4:0]           slot;
    logic [4:0]           bit_idx;

    always_comb begin
        held_d  = held_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        slot    = n[4:0];
        bit_idx = 5'(PCM_WIDTH) - slot;
        if (frame_start) begin
            if (mute_active) begin
                held_d = '0;
            end else if (!fifo_empty) begin
                held_d = mem_q[rd_ptr_q];
            end
        end
        if (fall) begin
            if (n == 6'd0) begin
                lrclk_d = 1'b0;
            end else if (n == 6'd32) begin
                lrclk_d = 1'b1;
            end
            // Slot 0 of each half is the I2S one-bit delay after lrclk.
            if (slot != 5'd0 && slot <= 5'(PCM_WIDTH)) begin
                sdata_d = held_q[bit_idx];
            end else begin
                sdata_d = 1'b0;
            end
        end
        ovf_d = (ovf_q & ~clear_flags) | ovf_set;
        unf_d = (unf_q & ~clear_flags) | unf_set;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= 6'd63;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            held_q    <= '0;
            lrclk_q   <= 1'b1;
            sdata_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            held_q    <= held_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_effect_dac_tx.sv
// Self-checking bench for effect_dac_tx with a queue-based reference model.
module tb_effect_dac_tx;

    localparam int unsigned D     = 2;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clear_flags = 1'b0;
    logic        mute = 1'b0;
    logic        bclk, lrclk, sdata, overflow, underflow;

    int checks   = 0;
    int failures = 0;

    effect_dac_tx #(
        .PCM_WIDTH  (24),
        .FIFO_DEPTH (DEPTH),
        .BCLK_DIV   (D)
    ) dut (
        .clk          (clk),
        .aclr         (aclr),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_flags  (clear_flags),
`ifdef DAC_TX_MUTE_EN
        .mute         (mute),
`endif
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion computed with real arithmetic from the float value.
    function automatic logic [23:0] f2p(input logic [31:0] f);
        int  e;
        int  mag;
        real v;
        e = int'(f[30:23]);
        if (e == 0) return 24'h0;
        if (e == 255 && f[22:0] != 23'd0) return 24'h0;
        if (e >= 127) return f[31] ? 24'h800000 : 24'h7FFFFF;
        v   = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 8388608.0;
        mag = $rtoi(v);
        return f[31] ? 24'(-mag) : 24'(mag);
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {r[31], 8'($urandom_range(100, 130)), r[22:0]};
            2:       return {r[31], 8'd255, (r[0] ? 23'd0 : r[22:0])};
            default: return {r[31], 8'(126 - $urandom_range(0, 3)), r[22:0]};
        endcase
    endfunction

    // ---------------- reference model ----------------
    int unsigned k;               // clk edges since reset release
    logic [23:0] mq[$];           // words stored in the FIFO
    int unsigned pend_due[$];     // edge at which a converted word is written
    logic [23:0] pend_val[$];
    logic [23:0] m_held;
    logic        m_ovf, m_unf;

    task automatic model_reset();
        k = 0;
        mq.delete();
        pend_due.delete();
        pend_val.delete();
        m_held = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step();
        logic        ovs, uns;
        logic [23:0] v;
        int unsigned f;
        ovs = 1'b0;
        uns = 1'b0;
        k++;
        if (k % (2 * D) == 0) begin
            f = k / (2 * D);
            if ((f - 1) % 64 == 0) begin
                if (mq.size() > 0) begin
                    v      = mq.pop_front();
                    m_held = mute ? 24'h0 : v;
                end else begin
                    uns = 1'b1;
                    if (mute) m_held = 24'h0;
                end
            end
        end
        while (pend_due.size() > 0 && pend_due[0] == k) begin
            void'(pend_due.pop_front());
            v = pend_val.pop_front();
            if (mq.size() < DEPTH) mq.push_back(v);
            else ovs = 1'b1;
        end
        if (sample_valid) begin
            pend_due.push_back(k + 2);
            pend_val.push_back(f2p(sample_in));
        end
        m_ovf = (m_ovf & ~clear_flags) | ovs;
        m_unf = (m_unf & ~clear_flags) | uns;
    endtask

    task automatic model_outputs(output logic eb, output logic el, output logic es);
        int unsigned f, n, m;
        eb = 1'((k / D) % 2);
        f  = k / (2 * D);
        if (f == 0) begin
            el = 1'b1;
            es = 1'b0;
        end else begin
            n  = (f - 1) % 64;
            m  = n % 32;
            el = (n >= 32);
            es = (m >= 1 && m <= 24) ? m_held[24 - m] : 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge aclr);
            if (aclr) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model, sampled on the falling clk edge.
    initial begin
        logic eb, el, es;
        forever begin
            @(negedge clk);
            if (failures < 40) begin
                model_outputs(eb, el, es);
                check("cyc_bclk", 32'(bclk), 32'(eb));
                check("cyc_lrclk", 32'(lrclk), 32'(el));
                check("cyc_sdata", 32'(sdata), 32'(es));
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
                check("cyc_underflow", 32'(underflow), 32'(m_unf));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] d);
        @(negedge clk);
        #1;
        sample_valid = v;
        sample_in    = d;
    endtask

    task automatic strobe(input logic [31:0] d);
        drive(1'b1, d);
        drive(1'b0, 32'h0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        #1 clear_flags = 1'b1;
        @(negedge clk);
        #1 clear_flags = 1'b0;
    endtask

    task automatic wait_lr_fall(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = lrclk;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (prev && !lrclk) begin
                ok = 1'b1;
                return;
            end
            prev = lrclk;
        end
    endtask

    task automatic wait_bclk_fall(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = bclk;
        for (int i = 0; i < 4 * D + 4; i++) begin
            @(negedge clk);
            if (prev && !bclk) begin
                ok = 1'b1;
                return;
            end
            prev = bclk;
        end
    endtask

    // Captures the next frame: bits at n=1..24 (left) and n=33..56 (right).
    task automatic capture_check(input string name, input logic [23:0] exp);
        logic [23:0] l, r;
        bit ok, o;
        l = '0;
        r = '0;
        wait_lr_fall(ok);
        for (int i = 0; i < 24; i++) begin
            wait_bclk_fall(o); ok &= o;
            l = {l[22:0], sdata};
        end
        for (int i = 0; i < 8; i++) begin
            wait_bclk_fall(o); ok &= o;
        end
        for (int i = 0; i < 24; i++) begin
            wait_bclk_fall(o); ok &= o;
            r = {r[22:0], sdata};
        end
        check({name, "_sync"}, 32'(ok), 32'd1);
        check({name, "_left"}, 32'(l), 32'(exp));
        check({name, "_right"}, 32'(r), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int cnt;

        // Literal pins for the reference conversion.
        check("conv_half", 32'(f2p(32'h3F000000)), 32'h400000);
        check("conv_neg_one", 32'(f2p(32'hBF800000)), 32'h800000);
        check("conv_two", 32'(f2p(32'h40000000)), 32'h7FFFFF);
        check("conv_nan", 32'(f2p(32'h7F800001)), 32'h000000);
        check("conv_tiny", 32'(f2p(32'h3089705F)), 32'h000000);
        check("conv_quarter", 32'(f2p(32'h3E800000)), 32'h200000);
        check("conv_neg_inf", 32'(f2p(32'hFF800000)), 32'h800000);

        #1 aclr = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_bclk", 32'(bclk), 32'd0);
        check("reset_lrclk", 32'(lrclk), 32'd1);
        check("reset_sdata", 32'(sdata), 32'd0);
        check("reset_flags", 32'({overflow, underflow}), 32'd0);
        #1 aclr = 1'b0;

        // Frame 0 starts with an empty FIFO; clear that underflow first.
        repeat (20) @(negedge clk);
        check("frame0_underflow", 32'(underflow), 32'd1);
        pulse_clear();

        strobe(32'h3F000000);
        capture_check("half", 24'h400000);
        strobe(32'hBF800000);
        capture_check("neg_one", 24'h800000);
        strobe(32'h40000000);
        capture_check("two", 24'h7FFFFF);
        strobe(32'h7F800001);
        capture_check("nan", 24'h000000);
        strobe(32'h3089705F);
        capture_check("tiny", 24'h000000);
        check("steady_flags", 32'({overflow, underflow}), 32'd0);

        // Five back-to-back strobes into a depth-4 FIFO.
        drive(1'b1, 32'h3F000000);
        drive(1'b1, 32'h3E800000);
        drive(1'b1, 32'hBF800000);
        drive(1'b1, 32'h40000000);
        drive(1'b1, 32'h3E000000);
        drive(1'b0, 32'h0);
        repeat (4) @(negedge clk);
        check("burst_overflow", 32'(overflow), 32'd1);
        capture_check("burst0", 24'h400000);
        capture_check("burst1", 24'h200000);
        capture_check("burst2", 24'h800000);
        capture_check("burst3", 24'h7FFFFF);
        capture_check("burst_repeat", 24'h7FFFFF);
        check("burst_underflow", 32'(underflow), 32'd1);
        pulse_clear();
        check("cleared_flags", 32'({overflow, underflow}), 32'd0);

        strobe(32'h3E800000);
        capture_check("quarter0", 24'h200000);
        check("quarter0_underflow", 32'(underflow), 32'd0);
        capture_check("quarter1", 24'h200000);
        check("quarter1_underflow", 32'(underflow), 32'd1);
        pulse_clear();
        check("quarter_cleared", 32'(underflow), 32'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            sample_valid = ($urandom_range(0, 149) == 0);
            sample_in    = rand_float();
            clear_flags  = ($urandom_range(0, 299) == 0);
`ifdef DAC_TX_MUTE_EN
            if ($urandom_range(0, 999) == 0) mute = ~mute;
`endif
        end
        @(negedge clk);
        #1;
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        mute         = 1'b0;

        // Reset asserted at n=40.
        wait_lr_fall(ok);
        check("n40_sync", 32'(ok), 32'd1);
        for (int i = 0; i < 40; i++) wait_bclk_fall(ok);
        #1 aclr = 1'b1;
        @(negedge clk);
        check("midreset_bclk", 32'(bclk), 32'd0);
        check("midreset_lrclk", 32'(lrclk), 32'd1);
        check("midreset_sdata", 32'(sdata), 32'd0);
        check("midreset_flags", 32'({overflow, underflow}), 32'd0);
        @(negedge clk);
        #1 aclr = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (!lrclk) begin
                cnt = i;
                break;
            end
        end
        check("restart_latency", 32'(cnt), 32'(2 * D));

`ifdef DAC_TX_MUTE_EN
        repeat (10) @(negedge clk);
        strobe(32'h3F000000);
        strobe(32'h3F000000);
        wait_lr_fall(ok);
        for (int i = 0; i < 10; i++) wait_bclk_fall(ok);
        #1 mute = 1'b1;
        capture_check("muted", 24'h000000);
        #1 mute = 1'b0;
`endif

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
